mbinit_sb_tx_arbiter: RTL
=========================

// Module: mbinit_sb_tx_arbiter
// PURPOSE
//  Round-robin arbiter sharing one sideband TX message port between NUM_REQ MBINIT requesters (e.g. CAL, REPAIRCLK, REPAIRVAL).
//  Grants one requester at a time, latches its message, holds valid until the sideband signals completion (busy falling edge).
//  Acks the winner, or times out and releases. Sits between the MBINIT sub-state FSMs and the sideband TX encoder.
// PARAMETERS
//  NUM_REQ        4      number of requesters (2..8)
//  MSG_W          4      sideband message code width
//  TIMEOUT_W      16     width of the no-completion timer
//  TIMEOUT_CYCLES 16'hFFFF  SEND cycles without completion before abandoning the message (>=2)
// PORTS
//  CLK                 in   1                clock, all logic on rising edge
//  rst                 in   1                synchronous, active-high reset
//  i_flush             in   1                training error/exit: abort current message, return to IDLE
//  i_req               in   NUM_REQ          per-requester request, level; held until ack/timeout
//  i_req_msg           in   NUM_REQ*MSG_W    messages, requester k at [k*MSG_W +: MSG_W]
//  i_falling_edge_busy in   1                sideband finished sending the presented message
//  o_TX_SbMessage      out  MSG_W            granted message, 0 when not valid
//  o_ValidOut          out  1                message valid to sideband
//  o_grant             out  NUM_REQ          one-hot current owner, 0 in IDLE
//  o_ack               out  NUM_REQ          1-cycle one-hot pulse: owner's message sent
//  o_timeout           out  1                1-cycle pulse: message abandoned
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE; all outputs 0; rr pointer=NUM_REQ-1 (so requester 0 has first priority); timer=0.
//  FSM states: IDLE, SEND.
//  IDLE: if i_flush=0 and any i_req: winner = first set bit scanning ptr+1, ptr+2, ... (mod NUM_REQ);
//   latch winner's msg, o_grant<=onehot(winner), timer<=0, ->SEND. Else stay; outputs 0.
//  Latency: req sampled in IDLE -> o_ValidOut=1 next cycle with latched message.
//  SEND: o_ValidOut=1, o_TX_SbMessage=latched msg (stable even if requester changes i_req_msg or drops i_req).
//   i_falling_edge_busy=1: o_ack[owner]<=1 for one cycle, ptr<=owner, o_grant<=0, ->IDLE.
//   else if timer==TIMEOUT_CYCLES-1: o_timeout<=1 for one cycle, no ack, ptr<=owner, ->IDLE.
//   else timer<=timer+1 (never wraps; saturates by leaving SEND).
//  Pulses o_ack/o_timeout are registered: asserted in the first IDLE cycle after SEND; o_ValidOut already 0 that cycle.
//  Back-to-back: the IDLE cycle carrying the ack also arbitrates; o_ValidOut gap between messages is exactly 1 cycle.
//  Requester must drop i_req in the cycle it sees o_ack, else it re-enters arbitration (lowest priority after its own grant).
//  Simultaneous falling edge and timer expiry: ack wins, o_timeout stays 0.
//  i_falling_edge_busy in IDLE: ignored.
//  i_flush=1 (any state): next cycle IDLE, o_ValidOut/o_grant/o_TX_SbMessage=0, no ack, no timeout, ptr unchanged;
//   no arbitration while i_flush=1.
//  rst mid-SEND: identical to reset, message dropped, no pulses.
//  Invariants: o_grant is zero or one-hot; o_ValidOut == |o_grant; o_ack and o_timeout never both 1.
// TESTING
//  T1 reset: rst=1 2 cycles with i_req=4'b1111 -> all outputs 0; release -> grant 4'b0001, valid next cycle with msg0.
//  T2 single: i_req[2]=1 msg=4'hA; falling edge 3 cycles into SEND -> o_TX_SbMessage=4'hA for 3 cycles, o_ack=4'b0100 1 cycle.
//  T3 round-robin: i_req=4'b1011 held, falling edge each SEND -> grant order 0,1,3,0,1; 1-cycle valid gap each.
//  T4 timeout: TIMEOUT_CYCLES=8, no falling edge -> valid high 8 cycles, o_timeout pulse, o_ack=0, next grant moves on.
//  T5 edge+expiry same cycle, and msg change mid-SEND -> o_ack only; o_TX_SbMessage keeps latched value.
//  T6 flush mid-SEND: i_flush 1 cycle -> next cycle outputs 0, no ack/timeout; after release, same requester regranted.

Source files
------------

// File: rtl/mbinit_sb_tx_arbiter.sv
// Round-robin arbiter that shares one sideband TX message port between the MBINIT
// sub-state requesters, holding each granted message until the sideband finishes or times out.
module mbinit_sb_tx_arbiter #(
  parameter int unsigned          NUM_REQ        = 4,
  parameter int unsigned          MSG_W          = 4,
  parameter int unsigned          TIMEOUT_W      = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [NUM_REQ*MSG_W-1:0] i_req_msg,
  input  logic                     i_falling_edge_busy,
  output logic [MSG_W-1:0]         o_TX_SbMessage,
  output logic                     o_ValidOut,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_ack,
  output logic                     o_timeout
);

  localparam int unsigned          PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]       NUM_REQ_V  = (PTR_W + 1)'(NUM_REQ);
  localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_CYCLES - TIMEOUT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [MSG_W-1:0]     msg_q, msg_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 timeout_q, timeout_d;

  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W:0]       cand;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [MSG_W-1:0]     win_msg;

  // Scan ptr+1, ptr+2, ... (mod NUM_REQ); the last owner therefore has lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PTR_W + 1)'(i);
      if (cand >= NUM_REQ_V) cand = cand - NUM_REQ_V;
      if (!win_found && i_req[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    win_msg    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (PTR_W'(k) == win_idx) begin
        win_onehot[k] = 1'b1;
        win_msg       = i_req_msg[k*MSG_W +: MSG_W];
      end
    end
  end

  // NOTE: every variable gets its hold/default value first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    msg_d     = msg_q;
    timer_d   = timer_q;
    ack_d     = '0;
    timeout_d = 1'b0;

    if (i_flush) begin
      state_d = IDLE;
      grant_d = '0;
      msg_d   = '0;
      timer_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_found) begin
            state_d = SEND;
            owner_d = win_idx;
            grant_d = win_onehot;
            msg_d   = win_msg;
            timer_d = '0;
          end
        end
        SEND: begin
          // Completion beats timer expiry when both land on the same cycle.
          if (i_falling_edge_busy) begin
            ack_d   = grant_q;
            ptr_d   = owner_q;
            state_d = IDLE;
            grant_d = '0;
            msg_d   = '0;
          end else if (timer_q == TIMER_LAST) begin
            timeout_d = 1'b1;
            ptr_d     = owner_q;
            state_d   = IDLE;
            grant_d   = '0;
            msg_d     = '0;
          end else begin
            timer_d = timer_q + TIMEOUT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_W'(NUM_REQ - 1);
      owner_q   <= '0;
      grant_q   <= '0;
      msg_q     <= '0;
      timer_q   <= '0;
      ack_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      msg_q     <= msg_d;
      timer_q   <= timer_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_ValidOut     = (state_q == SEND);
  assign o_grant        = grant_q;
  assign o_TX_SbMessage = msg_q;
  assign o_ack          = ack_q;
  assign o_timeout      = timeout_q;

endmodule
